// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_arb_pkg
// Brief    : Requester ids and access-size encodings for mem_req_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

  localparam logic REQ_INST = 1'b0;
  localparam logic REQ_DATA = 1'b1;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

endpackage
`default_nettype wire

// File: rtl/mem_req_arbiter_tag_fifo.sv
`default_nettype none
// ============================================================================
// Module   : arb_tag_fifo
// Brief    : In-order FIFO of 1-bit requester ids with simultaneous push/pop.
// Revision : 1.0 - initial release
// ============================================================================
module arb_tag_fifo #(
  parameter int DEPTH = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic push,
  input  logic push_id,
  input  logic pop,
  output logic pop_id,
  output logic full,
  output logic empty
);

  localparam int c_AW = $clog2(DEPTH);
  localparam logic [c_AW:0] c_FULL = (c_AW + 1)'(DEPTH);

  logic [DEPTH-1:0] r_mem;
  logic [c_AW-1:0]  r_wr_ptr;
  logic [c_AW-1:0]  r_rd_ptr;
  logic [c_AW:0]    r_count;
  logic             w_push_en;
  logic             w_pop_en;

  assign full      = (r_count == c_FULL);
  assign empty     = (r_count == '0);
  assign w_push_en = push && !full;
  assign w_pop_en  = pop && !empty;
  assign pop_id    = r_mem[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_en) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop_en)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push_en, w_pop_en})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage holds only ids; validity is tracked by the pointers, so no reset.
  always_ff @(posedge clk) begin
    if (w_push_en) r_mem[r_wr_ptr] <= push_id;
  end

endmodule
`default_nettype wire

// File: rtl/mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_req_arbiter
// Brief    : Shares one memory port between inst and data requesters and
//            routes in-order responses. Define MEM_ARB_RR_EN for round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int OUT_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [1:0]  inst_size,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [1:0]  data_size,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_req,
  output logic        mem_wr,
  output logic [1:0]  mem_size,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_addr_ok,
  input  logic        mem_data_ok,
  input  logic [31:0] mem_rdata
);

  logic w_fifo_full;
  logic w_fifo_empty;
  logic w_pop_id;
  logic w_pref_id;
  logic w_win_id;
  logic w_win_req;
  logic w_push;
  logic w_pop;
  logic r_lock;
  logic r_lock_id;

`ifdef MEM_ARB_RR_EN
  logic r_rr_ptr;

  // Prefer whichever requester did not win the most recent acceptance.
  always_ff @(posedge clk) begin
    if (reset)       r_rr_ptr <= REQ_DATA;
    else if (w_push) r_rr_ptr <= ~w_win_id;
  end

  assign w_pref_id = r_rr_ptr;
`else
  assign w_pref_id = REQ_DATA;
`endif

  always_comb begin
    w_win_id = w_pref_id;
    if (r_lock)                     w_win_id = r_lock_id;
    else if (inst_req && !data_req) w_win_id = REQ_INST;
    else if (data_req && !inst_req) w_win_id = REQ_DATA;
  end

  assign w_win_req = (w_win_id == REQ_DATA) ? data_req : inst_req;
  assign mem_req   = w_win_req && !w_fifo_full && !reset;
  assign mem_wr    = (w_win_id == REQ_DATA) ? data_wr    : inst_wr;
  assign mem_size  = (w_win_id == REQ_DATA) ? data_size  : inst_size;
  assign mem_addr  = (w_win_id == REQ_DATA) ? data_addr  : inst_addr;
  assign mem_wdata = (w_win_id == REQ_DATA) ? data_wdata : inst_wdata;

  assign w_push       = mem_req && mem_addr_ok;
  assign inst_addr_ok = w_push && (w_win_id == REQ_INST);
  assign data_addr_ok = w_push && (w_win_id == REQ_DATA);

  assign w_pop        = mem_data_ok && !w_fifo_empty && !reset;
  assign inst_data_ok = w_pop && (w_pop_id == REQ_INST);
  assign data_data_ok = w_pop && (w_pop_id == REQ_DATA);
  assign inst_rdata   = mem_rdata;
  assign data_rdata   = mem_rdata;

  // A request presented but not taken must stay granted until accepted;
  // the lock survives full-FIFO stalls because the request is still held.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_lock    <= 1'b0;
      r_lock_id <= REQ_DATA;
    end else if (mem_req && !mem_addr_ok) begin
      r_lock    <= 1'b1;
      r_lock_id <= w_win_id;
    end else if (w_push || !w_win_req) begin
      r_lock    <= 1'b0;
    end
  end

  arb_tag_fifo #(
    .DEPTH (OUT_DEPTH)
  ) u_tag_fifo (
    .clk     (clk),
    .reset   (reset),
    .push    (w_push),
    .push_id (w_win_id),
    .pop     (w_pop),
    .pop_id  (w_pop_id),
    .full    (w_fifo_full),
    .empty   (w_fifo_empty)
  );

endmodule
`default_nettype wire

// File: tb/tb_mem_req_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_req_arbiter
// Brief    : Directed self-checking bench for mem_req_arbiter (OUT_DEPTH=2).
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_req_arbiter;
  import mem_arb_pkg::*;

`ifdef MEM_ARB_RR_EN
  localparam int c_ROUNDS = 2;
`else
  localparam int c_ROUNDS = 1;
`endif

  logic        clk;
  logic        reset;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [1:0]  inst_size, data_size, mem_size;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        mem_req, mem_wr, mem_addr_ok, mem_data_ok;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int errors = 0;
  int checks = 0;

  mem_req_arbiter #(.OUT_DEPTH(2)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
    .inst_addr(inst_addr), .inst_wdata(inst_wdata),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    inst_req = 0; inst_wr = 0; inst_size = SZ_WORD; inst_addr = '0; inst_wdata = '0;
    data_req = 0; data_wr = 0; data_size = SZ_WORD; data_addr = '0; data_wdata = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset = 1; inst_req = 1; data_req = 1; mem_addr_ok = 1; mem_data_ok = 1;
    tick(); tick();
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL rst_mem_req: got %b exp 0", mem_req); end
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b00) begin errors++; $display("FAIL rst_addr_ok: got %b exp 00", {inst_addr_ok, data_addr_ok}); end
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL rst_data_ok: got %b exp 00", {inst_data_ok, data_data_ok}); end
    idle_inputs();
    tick();
    reset = 0;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL idle_mem_req: got %b exp 0", mem_req); end
  endtask

  task automatic test_inst_read();
    tick();
    inst_req = 1; inst_addr = 32'hbfc00000; inst_size = SZ_WORD; mem_addr_ok = 1;
    #1;
    checks++; if (mem_req !== 1'b1) begin errors++; $display("FAIL ird_mem_req: got %b exp 1", mem_req); end
    checks++; if (mem_addr !== 32'hbfc00000) begin errors++; $display("FAIL ird_mem_addr: got %h exp bfc00000", mem_addr); end
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL ird_addr_ok: got %b exp 10", {inst_addr_ok, data_addr_ok}); end
    checks++; if (mem_wr !== 1'b0) begin errors++; $display("FAIL ird_mem_wr: got %b exp 0", mem_wr); end
    tick();
    inst_req = 0; mem_addr_ok = 0;
    #1;
    checks++; if (inst_data_ok !== 1'b0) begin errors++; $display("FAIL ird_early_ok: got %b exp 0", inst_data_ok); end
    tick();
    mem_data_ok = 1; mem_rdata = 32'h3c1d0001;
    #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("FAIL ird_data_ok: got %b exp 10", {inst_data_ok, data_data_ok}); end
    checks++; if (inst_rdata !== 32'h3c1d0001) begin errors++; $display("FAIL ird_rdata: got %h exp 3c1d0001", inst_rdata); end
    tick();
    mem_data_ok = 0;
    #1;
    checks++; if (inst_data_ok !== 1'b0) begin errors++; $display("FAIL ird_one_shot: got %b exp 0", inst_data_ok); end
  endtask

  task automatic test_arbitration();
    for (int r = 0; r < c_ROUNDS; r++) begin
      tick();
      inst_req = 1; inst_addr = 32'h00001000;
      data_req = 1; data_addr = 32'h00002000; data_wr = 1; data_size = SZ_HALF;
      data_wdata = 32'hdeadbeef; mem_addr_ok = 1;
      #1;
      checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin errors++; $display("FAIL arb%0d_first: got %b exp 01", r, {inst_addr_ok, data_addr_ok}); end
      checks++; if (mem_addr !== 32'h00002000) begin errors++; $display("FAIL arb%0d_addr_d: got %h exp 00002000", r, mem_addr); end
      checks++; if ({mem_wr, mem_size} !== {1'b1, SZ_HALF}) begin errors++; $display("FAIL arb%0d_wr_size: got %b exp 101", r, {mem_wr, mem_size}); end
      checks++; if (mem_wdata !== 32'hdeadbeef) begin errors++; $display("FAIL arb%0d_wdata: got %h exp deadbeef", r, mem_wdata); end
      tick();
`ifndef MEM_ARB_RR_EN
      data_req = 0;
`endif
      #1;
      checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL arb%0d_second: got %b exp 10", r, {inst_addr_ok, data_addr_ok}); end
      checks++; if (mem_addr !== 32'h00001000) begin errors++; $display("FAIL arb%0d_addr_i: got %h exp 00001000", r, mem_addr); end
      tick();
      inst_req = 0; data_req = 0; data_wr = 0; mem_addr_ok = 0;
      mem_data_ok = 1; mem_rdata = 32'ha5a50000 + r;
      #1;
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin errors++; $display("FAIL arb%0d_resp1: got %b exp 01", r, {inst_data_ok, data_data_ok}); end
      tick();
      mem_rdata = 32'h5a5a0000 + r;
      #1;
      checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("FAIL arb%0d_resp2: got %b exp 10", r, {inst_data_ok, data_data_ok}); end
      checks++; if (inst_rdata !== 32'h5a5a0000 + r) begin errors++; $display("FAIL arb%0d_rdata: got %h exp %h", r, inst_rdata, 32'h5a5a0000 + r); end
      tick();
      mem_data_ok = 0;
    end
  endtask

  task automatic test_lock_and_full();
    tick();
    inst_req = 1; inst_addr = 32'h00003000; mem_addr_ok = 0;
    for (int c = 0; c < 3; c++) begin
      if (c >= 1) begin
        data_req = 1; data_addr = 32'h00004000;
      end
      #1;
      checks++; if ({mem_req, inst_addr_ok, data_addr_ok} !== 3'b100) begin errors++; $display("FAIL lock%0d_hs: got %b exp 100", c, {mem_req, inst_addr_ok, data_addr_ok}); end
      checks++; if (mem_addr !== 32'h00003000) begin errors++; $display("FAIL lock%0d_addr: got %h exp 00003000", c, mem_addr); end
      tick();
    end
    mem_addr_ok = 1;
    #1;
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b10) begin errors++; $display("FAIL lock_accept: got %b exp 10", {inst_addr_ok, data_addr_ok}); end
    checks++; if (mem_addr !== 32'h00003000) begin errors++; $display("FAIL lock_accept_addr: got %h exp 00003000", mem_addr); end
    tick();
    inst_req = 0;
    #1;
    checks++; if ({inst_addr_ok, data_addr_ok} !== 2'b01) begin errors++; $display("FAIL lock_then_data: got %b exp 01", {inst_addr_ok, data_addr_ok}); end
    checks++; if (mem_addr !== 32'h00004000) begin errors++; $display("FAIL lock_data_addr: got %h exp 00004000", mem_addr); end
    // Two outstanding now (inst, data): the FIFO is full.
    tick();
    data_req = 0; inst_req = 1; inst_addr = 32'h00005000;
    #1;
    checks++; if ({mem_req, inst_addr_ok} !== 2'b00) begin errors++; $display("FAIL full_block: got %b exp 00", {mem_req, inst_addr_ok}); end
    tick();
    mem_data_ok = 1; mem_rdata = 32'h00000011;
    #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b10) begin errors++; $display("FAIL full_pop_oldest: got %b exp 10", {inst_data_ok, data_data_ok}); end
    checks++; if ({mem_req, inst_addr_ok} !== 2'b00) begin errors++; $display("FAIL full_pop_no_push: got %b exp 00", {mem_req, inst_addr_ok}); end
    tick();
    mem_data_ok = 0;
    #1;
    checks++; if (inst_addr_ok !== 1'b1) begin errors++; $display("FAIL full_then_accept: got %b exp 1", inst_addr_ok); end
    checks++; if (mem_addr !== 32'h00005000) begin errors++; $display("FAIL full_accept_addr: got %h exp 00005000", mem_addr); end
    tick();
    inst_req = 0; mem_addr_ok = 0;
  endtask

  task automatic test_reset_flush();
    // Two transactions (data, inst) are still outstanding on entry.
    reset = 1;
    #1;
    checks++; if (mem_req !== 1'b0) begin errors++; $display("FAIL flush_rst_req: got %b exp 0", mem_req); end
    tick();
    reset = 0;
    tick();
    mem_data_ok = 1; mem_rdata = 32'h0000dead;
    #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL flush_stray: got %b exp 00", {inst_data_ok, data_data_ok}); end
    tick();
    mem_data_ok = 0; data_req = 1; data_addr = 32'h00006000; mem_addr_ok = 1;
    #1;
    checks++; if ({data_addr_ok, inst_addr_ok} !== 2'b10) begin errors++; $display("FAIL flush_new_req: got %b exp 10", {data_addr_ok, inst_addr_ok}); end
    tick();
    data_req = 0; mem_addr_ok = 0; mem_data_ok = 1; mem_rdata = 32'h00000077;
    #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b01) begin errors++; $display("FAIL flush_resp: got %b exp 01", {inst_data_ok, data_data_ok}); end
    checks++; if (data_rdata !== 32'h00000077) begin errors++; $display("FAIL flush_rdata: got %h exp 00000077", data_rdata); end
    tick();
    #1;
    checks++; if ({inst_data_ok, data_data_ok} !== 2'b00) begin errors++; $display("FAIL flush_empty: got %b exp 00", {inst_data_ok, data_data_ok}); end
    tick();
    mem_data_ok = 0;
  endtask

  initial begin
    test_reset();
    test_inst_read();
    test_arbitration();
    test_lock_and_full();
    test_reset_flush();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
